// File: rtl/apb4_master_bridge_pkg.sv
// Shared types and constants for the APB4 master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // APB4 PPROT bit meanings
  localparam logic [2:0] PROT_PRIV   = 3'b001;
  localparam logic [2:0] PROT_NSEC   = 3'b010;
  localparam logic [2:0] PROT_INSTR  = 3'b100;

  localparam int DEFAULT_ADDR_WIDTH  = 32;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_SLV_COUNT   = 4;
  localparam int DEFAULT_DEC_LSB     = 12;
  localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb4_master_bridge_if.sv
// Command/response stream plus APB4 master bus bundled into one interface.
interface apb4_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SLV_COUNT  = DEFAULT_SLV_COUNT
);

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [ADDR_WIDTH-1:0]         cmd_addr;
  logic [DATA_WIDTH-1:0]         cmd_wdata;
  logic [DATA_WIDTH/8-1:0]       cmd_strb;
  logic [2:0]                    cmd_prot;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          rsp_timeout;

  logic [ADDR_WIDTH-1:0]         PADDR;
  logic                          PWRITE;
  logic                          PENABLE;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic [DATA_WIDTH/8-1:0]       PSTRB;
  logic [2:0]                    PPROT;
  logic [SLV_COUNT-1:0]          PSEL;
  logic [SLV_COUNT-1:0]          PREADY;
  logic [SLV_COUNT-1:0]          PSLVERR;
  logic [SLV_COUNT*DATA_WIDTH-1:0] PRDATA;

  // Bridge side
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, rsp_ready,
    input  PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT, PSEL
  );

  // Host and slave side
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, rsp_ready,
    output PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT, PSEL
  );

endinterface

// File: rtl/apb4_master_bridge_rsp_mux.sv
// Selects the addressed slave's PREADY/PSLVERR/PRDATA.
module apb_rsp_mux
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SLV_COUNT  = DEFAULT_SLV_COUNT,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]                idx_i,
  input  logic [SLV_COUNT-1:0]            pready_i,
  input  logic [SLV_COUNT-1:0]            pslverr_i,
  input  logic [SLV_COUNT*DATA_WIDTH-1:0] prdata_i,
  output logic                            ready_o,
  output logic                            slverr_o,
  output logic [DATA_WIDTH-1:0]           rdata_o
);

  // Pick the lane matching idx; an index with no slave yields all zeros
  always_comb begin
    ready_o  = 1'b0;
    slverr_o = 1'b0;
    rdata_o  = '0;
    for (int i = 0; i < SLV_COUNT; i++) begin
      if (idx_i == SEL_W'(i)) begin
        ready_o  = pready_i[i];
        slverr_o = pslverr_i[i];
        rdata_o  = prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 master bridge: one command at a time, address-decoded slave select,
// per-slave response mux and an ACCESS-phase timeout.
module apb4_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SLV_COUNT   = DEFAULT_SLV_COUNT,
  parameter int DEC_LSB     = DEFAULT_DEC_LSB,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb4_master_bridge_if.master bus
);

  localparam int SEL_W  = (SLV_COUNT > 1) ? $clog2(SLV_COUNT) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  apb_state_e            state_q, state_d;
  logic                  run_q;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  write_q, write_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;

  logic [SEL_W-1:0]      cmd_idx;
  logic                  dec_ok;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [SLV_COUNT-1:0]  psel;

  assign cmd_idx = bus.cmd_addr[DEC_LSB +: SEL_W];
  // Non-power-of-two slave counts leave unused index codes; those are decode errors
  assign dec_ok  = (32'(cmd_idx) < 32'(SLV_COUNT));

  apb_rsp_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLV_COUNT  (SLV_COUNT),
    .SEL_W      (SEL_W)
  ) u_rsp_mux (
    .idx_i     (idx_q),
    .pready_i  (bus.PREADY),
    .pslverr_i (bus.PSLVERR),
    .prdata_i  (bus.PRDATA),
    .ready_o   (sel_ready),
    .slverr_o  (sel_slverr),
    .rdata_o   (sel_rdata)
  );

  // State and datapath registers; reset aborts any transfer without a response
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic for the transfer sequence and response capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (run_q && bus.cmd_valid) begin
          idx_d   = cmd_idx;
          addr_d  = bus.cmd_addr;
          write_d = bus.cmd_write;
          prot_d  = bus.cmd_prot;
          // Reads never present data or strobes on the bus
          wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
          strb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          if (dec_ok) begin
            state_d = SETUP;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            tmo_d   = 1'b0;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A slave completing on the expiry cycle still counts as a completion
        if (sel_ready) begin
          state_d = RESP;
          err_d   = sel_slverr;
          tmo_d   = 1'b0;
          rdata_d = (write_q || sel_slverr) ? '0 : sel_rdata;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == TO_LAST)) begin
          state_d = RESP;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot select, active only while a transfer is on the bus
  always_comb begin
    psel = '0;
    if ((state_q == SETUP) || (state_q == ACCESS)) begin
      for (int i = 0; i < SLV_COUNT; i++) begin
        if (idx_q == SEL_W'(i)) psel[i] = 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = run_q && (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;

  assign bus.PSEL    = psel;
  assign bus.PENABLE = (state_q == ACCESS);
  assign bus.PADDR   = addr_q;
  assign bus.PWRITE  = write_q;
  assign bus.PWDATA  = wdata_q;
  assign bus.PSTRB   = strb_q;
  assign bus.PPROT   = prot_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed bench for apb4_master_bridge with a response scoreboard.
module tb_apb4_master_bridge;

  logic clk = 1'b0;
  logic PRESETn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4)) bus ();
  apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(3)) bus3 ();

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4),
                       .DEC_LSB(12), .TIMEOUT_CYC(16))
    dut (.PCLK(clk), .PRESETn(PRESETn), .bus(bus));

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(3),
                       .DEC_LSB(12), .TIMEOUT_CYC(16))
    dut3 (.PCLK(clk), .PRESETn(PRESETn), .bus(bus3));

  // Slave model: ready after wait_cyc ACCESS cycles, optional error, fixed read data
  int   wait_cyc = 0;
  logic never_rdy = 1'b0;
  logic slv_err = 1'b0;
  int   acc_cnt = 0;
  always @(posedge clk) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
  assign bus.PREADY  = (bus.PENABLE && !never_rdy && acc_cnt >= wait_cyc) ? bus.PSEL : 4'b0;
  assign bus.PSLVERR = slv_err ? bus.PREADY : 4'b0;
  assign bus.PRDATA  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0BAD_F00D};

  assign bus3.PREADY  = 3'b0;
  assign bus3.PSLVERR = 3'b0;
  assign bus3.PRDATA  = '0;
  assign bus3.rsp_ready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: compare each response at its handshake, and watch PENABLE/PSEL pairing
  always @(negedge clk) begin
    if (PRESETn && bus.rsp_valid && bus.rsp_ready) begin
      check("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rd));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
      end
    end
    if (bus.PENABLE) check("penable_without_psel", 64'(|bus.PSEL), 64'd1);
  end

  // Results of the last run_cmd
  int          r_lat, r_pen, r_wait;
  logic [3:0]  r_psel;
  logic        r_strb_bad;
  logic [31:0] s_paddr, s_pwdata;
  logic [3:0]  s_pstrb;
  logic [2:0]  s_pprot;
  logic        s_penable, s_pwrite;

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the handshake
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot,
                         input logic [31:0] exp_rd, input logic exp_err, input logic exp_tmo,
                         input int hold);
    exp_t e;
    int   acc, n;
    logic [31:0] h_rd;
    logic        h_err;
    e.rd = exp_rd; e.err = exp_err; e.tmo = exp_tmo;
    exp_q.push_back(e);
    if (hold > 0) bus.rsp_ready = 1'b0;
    bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    bus.cmd_strb = strb; bus.cmd_prot = prot; bus.cmd_valid = 1'b1;
    r_wait = 0;
    while (!bus.cmd_ready && r_wait < 50) begin @(negedge clk); r_wait++; end
    if (!bus.cmd_ready) begin
      check("accept_bound", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
      void'(exp_q.pop_back());
      bus.rsp_ready = 1'b1;
      return;
    end
    acc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    s_paddr = bus.PADDR; s_pwdata = bus.PWDATA; s_pstrb = bus.PSTRB;
    s_pprot = bus.PPROT; s_penable = bus.PENABLE; s_pwrite = bus.PWRITE;
    r_pen = 0; r_psel = '0; r_strb_bad = 1'b0; n = 0;
    while (!bus.rsp_valid && n < 100) begin
      r_pen += int'(bus.PENABLE);
      r_psel |= bus.PSEL;
      if (!bus.PWRITE && (|bus.PSEL) && (bus.PSTRB != 4'h0)) r_strb_bad = 1'b1;
      @(negedge clk); n++;
    end
    check("rsp_valid_bound", 64'(bus.rsp_valid), 64'd1);
    r_lat = bus.rsp_valid ? cyc - acc : -1;
    if (hold > 0) begin
      h_rd = bus.rsp_rdata; h_err = bus.rsp_err;
      repeat (hold) @(negedge clk);
      check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("rsp_hold_stable", {31'd0, bus.rsp_err, bus.rsp_rdata}, {31'd0, h_err, h_rd});
      @(posedge clk); #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    n = 0;
    while (bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    logic [2:0] p3;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_strb = '0; bus.cmd_prot = '0; bus.rsp_ready = 1'b1;
    bus3.cmd_valid = 1'b0; bus3.cmd_write = 1'b0; bus3.cmd_addr = '0; bus3.cmd_wdata = '0;
    bus3.cmd_strb = '0; bus3.cmd_prot = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_psel", 64'(bus.PSEL), 64'd0);
    check("rst_penable", 64'(bus.PENABLE), 64'd0);
    check("rst_paddr", 64'(bus.PADDR), 64'd0);
    PRESETn = 1'b1;
    @(negedge clk);

    // Write to slave 1, ready at once: minimum latency
    wait_cyc = 0; slv_err = 1'b0; never_rdy = 1'b0;
    run_cmd(1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'hF, 3'b010, 32'h0, 1'b0, 1'b0, 0);
    check("t1_latency", 64'(r_lat), 64'd3);
    check("t1_psel", 64'(r_psel), 64'b0010);
    check("t1_setup_penable", 64'(s_penable), 64'd0);
    check("t1_setup_paddr", 64'(s_paddr), 64'h1004);
    check("t1_setup_pwdata", 64'(s_pwdata), 64'hA5A5_0001);
    check("t1_setup_pstrb", 64'(s_pstrb), 64'hF);
    check("t1_setup_pprot", 64'(s_pprot), 64'b010);
    check("t1_setup_pwrite", 64'(s_pwrite), 64'd1);
    check("t1_access_cycles", 64'(r_pen), 64'd1);

    // Read slave 2 with three wait states; data and strobes must stay clean
    wait_cyc = 3;
    run_cmd(1'b0, 32'h0000_2008, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    check("t2_access_cycles", 64'(r_pen), 64'd4);
    check("t2_psel", 64'(r_psel), 64'b0100);
    check("t2_pstrb_zero", 64'(r_strb_bad), 64'd0);
    check("t2_setup_pwdata_zero", 64'(s_pwdata), 64'd0);

    // Back-to-back write to slave 0 with PSLVERR
    wait_cyc = 0; slv_err = 1'b1;
    run_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 3'b001, 32'h0, 1'b1, 1'b0, 0);
    check("t3_b2b_accept_wait", 64'(r_wait), 64'd0);
    check("t3_psel", 64'(r_psel), 64'b0001);

    // Read with PSLVERR returns zero data
    run_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b0, 0);
    slv_err = 1'b0;

    // Slave 3 never ready: timeout after 16 ACCESS cycles
    never_rdy = 1'b1;
    run_cmd(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b1, 0);
    check("t4_access_cycles", 64'(r_pen), 64'd16);
    check("t4_psel", 64'(r_psel), 64'b1000);
    check("t4_psel_dropped", 64'(bus.PSEL), 64'd0);
    never_rdy = 1'b0;

    // Index field is two bits, so 0x5000 decodes to slave 1; response held by rsp_ready
    wait_cyc = 1;
    run_cmd(1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b101, 32'h1111_1111, 1'b0, 1'b0, 3);
    check("t5_alias_psel", 64'(r_psel), 64'b0010);

    // Three-slave bridge: index 3 has no slave, so no APB transfer and an error
    bus3.cmd_addr = 32'h0000_3000; bus3.cmd_write = 1'b0; bus3.cmd_valid = 1'b1;
    n = 0;
    while (!bus3.cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("dec_accept", 64'(bus3.cmd_ready), 64'd1);
    acc = cyc;
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    p3 = '0; n = 0;
    while (!bus3.rsp_valid && n < 10) begin p3 |= bus3.PSEL; @(negedge clk); n++; end
    check("dec_rsp_valid", 64'(bus3.rsp_valid), 64'd1);
    check("dec_latency_in_range", 64'(((cyc - acc) >= 1) && ((cyc - acc) <= 2)), 64'd1);
    check("dec_rsp_err", 64'(bus3.rsp_err), 64'd1);
    check("dec_rsp_timeout", 64'(bus3.rsp_timeout), 64'd0);
    check("dec_rsp_rdata", 64'(bus3.rsp_rdata), 64'd0);
    check("dec_no_psel", 64'(p3), 64'd0);
    @(negedge clk);

    // Reset during ACCESS: bus released at once, no response produced
    never_rdy = 1'b1;
    bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_2000; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.PENABLE && n < 10) begin @(negedge clk); n++; end
    check("rst_mid_in_access", 64'(bus.PENABLE), 64'd1);
    @(negedge clk);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_psel", 64'(bus.PSEL), 64'd0);
    check("rst_mid_penable", 64'(bus.PENABLE), 64'd0);
    check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    PRESETn = 1'b1;
    never_rdy = 1'b0; wait_cyc = 0;
    run_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    check("post_rst_latency", 64'(r_lat), 64'd3);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
